// File: rtl/vga_sink_monitor.sv
// vga_sink_monitor: passive checker for a VGA pixel stream.
// Samples hs/vs and 12-bit RGB on pix_en cycles and measures line and frame
// timing against the configured mode. It reports lock, sticky timing errors
// and a per-frame checksum of the active-area pixels.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   pix_en             pixel-rate enable; nothing advances without it
//   hs, vs             sync inputs, asserted level given by SYNC_POL
//   r, g, b            4-bit colour components
//   clr_err            clears err_h/err_v (a coincident new error wins)
//   locked             timing matched for a full frame
//   err_h, err_v       sticky line / frame timing errors
//   frame_done         one-clk pulse at the end of each measured frame
//   checksum           24-bit active-pixel sum of the last measured frame
//   frame_cnt          number of frame_done pulses, wraps
module vga_sink_monitor #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pix_en,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic        clr_err,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic        frame_done,
  output logic [23:0] checksum,
  output logic [15:0] frame_cnt
);

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;
  localparam int unsigned AW = 24;
  localparam int unsigned CW = 16;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] H_ACT_LO    = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_HI    = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [HW-1:0] H_MAX       = {HW{1'b1}};
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LO    = VW'(V_BP + V_SYNC);
  localparam logic [VW-1:0] V_ACT_HI    = VW'(V_BP + V_SYNC + V_ACTIVE - 1);
  localparam logic [VW-1:0] V_MAX       = {VW{1'b1}};
  localparam logic          SYNC_LVL    = 1'(SYNC_POL);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          hs_d;
  logic          vs_d;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [AW-1:0] acc;
  logic          frame_bad;

  logic [HW-1:0] h_cnt_nxt;
  logic [VW-1:0] v_cnt_nxt;
  logic [AW-1:0] acc_nxt;
  logic          frame_bad_nxt;
  logic          err_h_nxt;
  logic          err_v_nxt;
  logic          locked_nxt;
  logic          frame_done_nxt;
  logic [AW-1:0] checksum_nxt;
  logic [CW-1:0] frame_cnt_nxt;

  // Sync edge detection, qualified by pix_en so every event is a pixel event.
  logic hs_a;
  logic vs_a;
  logic hs_rise;
  logic hs_fall;
  logic vs_rise;
  logic measuring;
  logic h_err_ev;
  logic v_err_ev;
  logic pix_active;

  assign hs_a    = (hs == SYNC_LVL);
  assign vs_a    = (vs == SYNC_LVL);
  assign hs_rise = pix_en & hs_a & ~hs_d;
  assign hs_fall = pix_en & ~hs_a & hs_d;
  assign vs_rise = pix_en & vs_a & ~vs_d;

  assign measuring = (state == ST_MEASURE) || (state == ST_LOCKED);

  // Timing checks compare the count reached just before the edge.
  assign h_err_ev = measuring &
                    ((hs_rise & (h_cnt != H_LAST)) |
                     (hs_fall & (h_cnt != H_SYNC_LAST)));
  assign v_err_ev = measuring & vs_rise & (v_cnt != V_LAST);

  // Active window uses pre-update counts; the vs rise pixel starts a new sum.
  assign pix_active = pix_en & ~vs_rise &
                      (h_cnt >= H_ACT_LO) && (h_cnt <= H_ACT_HI) &&
                      (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_HI);

  // Counter and accumulator next values.
  always_comb begin
    h_cnt_nxt = h_cnt;
    v_cnt_nxt = v_cnt;
    acc_nxt   = acc;
    if (pix_en) begin
      if (hs_rise) begin
        h_cnt_nxt = '0;
      end else if (h_cnt != H_MAX) begin
        h_cnt_nxt = h_cnt + HW'(1);
      end

      if (vs_rise) begin
        v_cnt_nxt = '0;
      end else if (hs_rise && (v_cnt != V_MAX)) begin
        v_cnt_nxt = v_cnt + VW'(1);
      end

      if (vs_rise) begin
        acc_nxt = '0;
      end else if (pix_active) begin
        acc_nxt = acc + AW'({r, g, b});
      end
    end
  end

  // Sync, counters and accumulator registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      acc   <= '0;
    end else if (pix_en) begin
      hs_d  <= hs_a;
      vs_d  <= vs_a;
      h_cnt <= h_cnt_nxt;
      v_cnt <= v_cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, error flags and frame reporting.
  always_comb begin
    state_nxt      = state;
    frame_bad_nxt  = frame_bad;
    err_h_nxt      = err_h;
    err_v_nxt      = err_v;
    checksum_nxt   = checksum;
    frame_cnt_nxt  = frame_cnt;
    frame_done_nxt = 1'b0;

    if (pix_en && clr_err) begin
      err_h_nxt = 1'b0;
      err_v_nxt = 1'b0;
    end
    if (h_err_ev) begin
      err_h_nxt = 1'b1;
    end
    if (v_err_ev) begin
      err_v_nxt = 1'b1;
    end
    if (h_err_ev || v_err_ev) begin
      frame_bad_nxt = 1'b1;
    end

    // An error seen on the closing vs rise still belongs to the ending frame.
    unique case (state)
      ST_SEARCH: begin
        if (vs_rise) begin
          state_nxt     = ST_MEASURE;
          frame_bad_nxt = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (vs_rise) begin
          if (!(frame_bad || h_err_ev || v_err_ev)) begin
            state_nxt = ST_LOCKED;
          end
          frame_bad_nxt = 1'b0;
        end
      end
      ST_LOCKED: begin
        if (h_err_ev || v_err_ev) begin
          state_nxt = ST_MEASURE;
        end
        if (vs_rise) begin
          frame_bad_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = ST_SEARCH;
        frame_bad_nxt = 1'b0;
      end
    endcase

    if (measuring && vs_rise) begin
      checksum_nxt   = acc;
      frame_cnt_nxt  = frame_cnt + CW'(1);
      frame_done_nxt = 1'b1;
    end

    locked_nxt = (state_nxt == ST_LOCKED);
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_bad  <= 1'b0;
      err_h      <= 1'b0;
      err_v      <= 1'b0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      checksum   <= '0;
      frame_cnt  <= '0;
    end else begin
      frame_bad  <= frame_bad_nxt;
      err_h      <= err_h_nxt;
      err_v      <= err_v_nxt;
      locked     <= locked_nxt;
      frame_done <= frame_done_nxt;
      checksum   <= checksum_nxt;
      frame_cnt  <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sink_monitor.sv
// Bench for vga_sink_monitor in a reduced 16x12 mode: frames are generated
// from a table of frame descriptors, expected per-frame results are queued
// when each frame closes and checked when frame_done is seen.
module tb_vga_sink_monitor;

  localparam int unsigned H_TOTAL  = 16;
  localparam int unsigned H_SYNC   = 2;
  localparam int unsigned H_BP     = 2;
  localparam int unsigned H_ACTIVE = 8;
  localparam int unsigned V_TOTAL  = 12;
  localparam int unsigned V_SYNC   = 1;
  localparam int unsigned V_BP     = 1;
  localparam int unsigned V_ACTIVE = 6;
  localparam logic        SYNC_LVL = 1'b0;

  // Pixel k of a line sees horizontal count k-1 (the count clears on the
  // hs rise pixel); pixels after the first of line L see vertical count L.
  localparam int PX_LO = int'(H_SYNC + H_BP) + 1;
  localparam int PX_HI = int'(H_SYNC + H_BP + H_ACTIVE);
  localparam int LN_LO = int'(V_SYNC + V_BP);
  localparam int LN_HI = int'(V_SYNC + V_BP + V_ACTIVE) - 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pix_en = 1'b0;
  logic        hs = ~SYNC_LVL;
  logic        vs = ~SYNC_LVL;
  logic [3:0]  r = '0;
  logic [3:0]  g = '0;
  logic [3:0]  b = '0;
  logic        clr_err = 1'b0;
  logic        locked;
  logic        err_h;
  logic        err_v;
  logic        frame_done;
  logic [23:0] checksum;
  logic [15:0] frame_cnt;

  vga_sink_monitor #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE),
    .SYNC_POL(0)
  ) dut (
    .clk(clk), .rstn(rstn), .pix_en(pix_en), .hs(hs), .vs(vs),
    .r(r), .g(g), .b(b), .clr_err(clr_err),
    .locked(locked), .err_h(err_h), .err_v(err_v),
    .frame_done(frame_done), .checksum(checksum), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // One frame: line count, a line of odd length, a line with a 1-pixel
  // hsync, colour mode, idle clocks between pixels, where to pulse clr_err
  // and the flags expected then, and the results expected when it closes.
  typedef struct {
    int lines;
    int bad_line;
    int bad_len;
    int hsw_line;
    int color;
    int gap;
    int clr_line;
    int clr_px;
    bit clr_eh;
    bit clr_ev;
    bit lk;
    bit eh;
    bit ev;
  } frame_vec_t;

  typedef struct {
    logic [23:0] sum;
    logic [15:0] cnt;
    logic        lk;
    logic        eh;
    logic        ev;
  } exp_t;

  frame_vec_t rows [14];
  exp_t       sb_q [$];
  exp_t       pending;
  bit         pending_valid = 1'b0;
  int         exp_cnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err_h"}, 32'(err_h), 32'd0);
    check({tag, "_err_v"}, 32'(err_v), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  // Starts and ends on a falling clk edge.
  task automatic drive_pixel(input logic hs_on, input logic vs_on, input logic [11:0] v,
                             input logic clr, input int gap);
    hs = hs_on ? SYNC_LVL : ~SYNC_LVL;
    vs = vs_on ? SYNC_LVL : ~SYNC_LVL;
    {r, g, b} = v;
    clr_err = clr;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    clr_err = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drive_frame(input frame_vec_t f, input int max_lines);
    logic [23:0] sum;
    logic [11:0] pixv;
    logic        clr;
    int          len;
    int          hsw;
    sum = '0;
    for (int ln = 0; ln < f.lines && ln < max_lines; ln++) begin
      len = (ln == f.bad_line) ? f.bad_len : int'(H_TOTAL);
      hsw = (ln == f.hsw_line) ? 1 : int'(H_SYNC);
      for (int px = 0; px < len; px++) begin
        case (f.color)
          0:       pixv = 12'hF00;
          1:       pixv = (px == 0) ? 12'd0 : 12'(px - 1);
          default: pixv = 12'($urandom);
        endcase
        if (ln == 0 && px == 0 && pending_valid) sb_q.push_back(pending);
        clr = (ln == f.clr_line) && (px == f.clr_px);
        drive_pixel(px < hsw, ln < int'(V_SYNC), pixv, clr, f.gap);
        if (px >= PX_LO && px <= PX_HI && ln >= LN_LO && ln <= LN_HI) sum = sum + 24'(pixv);
        if ((f.bad_line >= 0 && ln == f.bad_line + 1 && px == 0) || (ln == f.hsw_line && px == 1)) begin
          check("edge_err_h", 32'(err_h), 32'd1);
          check("edge_locked", 32'(locked), 32'd0);
        end
        if (clr) begin
          check("clr_err_h", 32'(err_h), 32'(f.clr_eh));
          check("clr_err_v", 32'(err_v), 32'(f.clr_ev));
        end
      end
    end
    if (max_lines >= f.lines) begin
      exp_cnt++;
      pending = '{sum, 16'(exp_cnt), f.lk, f.eh, f.ev};
      pending_valid = 1'b1;
    end else begin
      pending_valid = 1'b0;
    end
  endtask

  // Closing vs rise for the last frame of a stream.
  task automatic end_stream();
    if (pending_valid) sb_q.push_back(pending);
    pending_valid = 1'b0;
    drive_pixel(1'b1, 1'b1, 12'h000, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (prev_done) check("done_width", 32'(frame_done), 32'd0);
        if (frame_done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(frame_cnt), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("checksum", 32'(checksum), 32'(e.sum));
            check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
            check("locked", 32'(locked), 32'(e.lk));
            check("err_h", 32'(err_h), 32'(e.eh));
            check("err_v", 32'(err_v), 32'(e.ev));
          end
        end
      end
      prev_done = frame_done;
    end
  endtask

  initial begin
    //           lines bad blen hsw col gap cl cpx ceh cev lk eh ev
    rows[0]  = '{12, -1, 16, -1, 0, 3, -1, 0, 0, 0, 1, 0, 0};
    rows[1]  = '{12, -1, 16, -1, 1, 0, -1, 0, 0, 0, 1, 0, 0};
    rows[2]  = '{12, -1, 16, -1, 2, 1, -1, 0, 0, 0, 1, 0, 0};
    rows[3]  = '{12,  3, 15, -1, 1, 0, -1, 0, 0, 0, 0, 1, 0};
    rows[4]  = '{12, -1, 16, -1, 0, 2, -1, 0, 0, 0, 1, 1, 0};
    rows[5]  = '{12, -1, 16,  5, 2, 0,  0, 1, 0, 0, 0, 1, 0};
    rows[6]  = '{12, -1, 16, -1, 1, 1, -1, 0, 0, 0, 1, 1, 0};
    rows[7]  = '{11, -1, 16, -1, 0, 0, -1, 0, 0, 0, 0, 1, 1};
    rows[8]  = '{12, -1, 16, -1, 2, 0, -1, 0, 0, 0, 1, 1, 1};
    rows[9]  = '{12, -1, 16, -1, 1, 0,  0, 1, 0, 0, 1, 0, 0};
    rows[10] = '{12, -1, 16,  2, 0, 1,  2, 1, 1, 0, 0, 1, 0};
    rows[11] = '{12, -1, 16, -1, 1, 0, -1, 0, 0, 0, 1, 1, 0};
    rows[12] = '{12, -1, 16, -1, 1, 3, -1, 0, 0, 0, 1, 0, 0};
    rows[13] = '{12, -1, 16, -1, 0, 0, -1, 0, 0, 0, 1, 0, 0};

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values, held and just after release.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int i = 0; i <= 11; i++) drive_frame(rows[i], 100);

    // Partial frame while locked (its vs rise closes row 11), then reset mid-frame.
    drive_frame(rows[13], 5);
    check("pre_reset_locked", 32'(locked), 32'd1);
    check("pre_reset_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    #2 rstn = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    sb_q.delete();
    pending_valid = 1'b0;
    exp_cnt = 0;
    rstn = 1'b1;
    @(negedge clk);

    // After release the first report comes at the second vs rise.
    for (int i = 12; i <= 13; i++) drive_frame(rows[i], 100);
    end_stream();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sink_monitor.md
# vga_sink_monitor

Passive receiver for the VGA output of the display path. It samples `hs`, `vs` and 12-bit RGB on pixel-enable cycles and measures the sync timing against the configured mode. It declares lock, flags timing errors and produces a per-frame checksum of active-area pixels, so benches and on-board self-test can check the generator end to end.

## Interface
Parameters:
- `H_TOTAL`, 800: pixels per line
- `H_SYNC`, 96: hsync width in pixels
- `H_BP`, 48: horizontal back porch
- `H_ACTIVE`, 640: active pixels per line
- `V_TOTAL`, 525: lines per frame
- `V_SYNC`, 2: vsync width in lines (informational; not checked)
- `V_BP`, 33: vertical back porch in lines
- `V_ACTIVE`, 480: active lines
- `SYNC_POL`, 0: sync asserted level (0 = active-low)

Ports:
- `clk`  in  1  system clock; all inputs are synchronous to it
- `rstn`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  pixel-rate enable; all sampling and counting happens only when it is 1
- `hs`, `vs`  in  1 each  sync inputs
- `r`, `g`, `b`  in  4 each  colour inputs
- `clr_err`  in  1  clears the sticky error flags
- `locked`  out  1  timing matched for a full frame
- `err_h`  out  1  sticky line-timing error
- `err_v`  out  1  sticky frame-timing error
- `frame_done`  out  1  one-clk pulse at end of each measured frame
- `checksum`  out  24  active-pixel sum of the last measured frame
- `frame_cnt`  out  16  number of `frame_done` pulses, wraps

## Operation
- Asserted sync means `hs == SYNC_POL` (same for `vs`). On each `pix_en`, `hs_d`/`vs_d` <= the current asserted state. hs rise = asserted now and not `hs_d`; hs fall = deasserted now and `hs_d`; vs rise is defined the same way.
- `h_cnt` (12 bit): 0 on hs rise, else +1, saturating at 4095.
- `v_cnt` (11 bit): 0 on vs rise, else +1 on hs rise, saturating. vs rise takes priority over a coincident hs rise.
- A pixel is active when `h_cnt` is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and `v_cnt` is in [V_BP+V_SYNC, V_BP+V_SYNC+V_ACTIVE-1], both evaluated with pre-update values.
- `acc` (24 bit): on an active pixel, `acc += {r,g,b}` modulo 2^24. On vs rise, `acc` <= 0 and the current pixel is not added.
- FSM states are SEARCH, MEASURE and LOCKED; reset enters SEARCH.
  - SEARCH: first vs rise -> MEASURE, and `frame_bad` <= 0.
  - MEASURE, vs rise: if `frame_bad` is 0 -> LOCKED; otherwise stay in MEASURE. `frame_bad` <= 0 in both cases.
  - LOCKED, any error event: -> MEASURE.
- Error events are checked only in MEASURE and LOCKED:
  - hs rise with `h_cnt != H_TOTAL-1`: set `err_h` and `frame_bad`.
  - hs fall with `h_cnt != H_SYNC-1`: set `err_h` and `frame_bad`.
  - vs rise with `v_cnt != V_TOTAL-1`: set `err_v` and `frame_bad`.
- On vs rise in MEASURE or LOCKED, with or without errors:
  - `checksum` <= `acc` + current contribution (0).
  - `frame_cnt` += 1.
  - `frame_done` = 1.
- `clr_err` clears `err_h`/`err_v`. If a new error is set in the same cycle, the set wins.
- `locked` = (state == LOCKED).

## Timing
- Reset values:
  - `locked`, `err_h`, `err_v`, `frame_done` are 0.
  - `checksum` is 0 and `frame_cnt` is 0.
  - All counters and `acc` are 0; `hs_d`/`vs_d` are 0.
- Latency: every output updates at the clk edge that ends the `pix_en` cycle containing the event.
- `frame_done` stays high exactly one clk cycle, even when `pix_en` is continuously 1.
- With `pix_en` = 0, state is frozen except that `frame_done` returns to 0.
- Lock happens at the second vs rise after reset in a clean stream. Loss of lock happens at the clk edge of the offending event.
- A reset mid-frame clears everything asynchronously. After release the block behaves exactly as after power-up; the partial frame is never reported.

## Test plan
- Ideal 640x480 stream, `pix_en` every 4th clk, constant RGB 12'hF00:
  - `locked` rises at the 2nd vs rise.
  - Each `frame_done` gives `checksum` = 24'h500000.
  - `frame_cnt` increments by 1 per frame; `err_h`/`err_v` stay 0.
- Reduced mode (H_TOTAL=16, H_SYNC=2, H_BP=2, H_ACTIVE=8, V_TOTAL=12, V_BP=1, V_SYNC=1, V_ACTIVE=6) with pixel value = `h_cnt`:
  - Per-line sum is 4+5+…+11 = 60.
  - `checksum` = 360 per frame.
- While locked, one line of 799 pixels:
  - `err_h` = 1 and `locked` = 0 at that hs rise.
  - Relock at the vs rise ending the next clean frame.
  - `err_h` stays 1 until `clr_err`.
- Hsync width 95 -> `err_h`. Frame of 524 lines -> `err_v`; `frame_done` still pulses.
- Pulse `clr_err` in the same cycle as a new hs error -> `err_h` remains 1.
- Assert `rstn` low mid-frame while locked:
  - All outputs are 0 immediately.
  - After release, the first `frame_done` comes at the 2nd vs rise.
